xctcmsg_piton_noc_serializer: RTL and testbench

- Multi-channel egress serializer from xctcmsg message sources onto one OpenPiton NoC physical channel, 64-bit flits, val/rdy handshake.
- Round-robin arbitration across NUM_CHANNELS requesters. The grantee's message is captured and emitted as one header flit followed by 0..MAX_PAYLOAD_FLITS payload flits.
- Payload length is variable per message, not fixed. The NoC header is built internally: destination id maps to chipid/x/y, and the length field is filled from the message.

---
 rtl/xctcmsg_piton_pkg.sv | 52 +++++
 rtl/xctcmsg_rr_arbiter.sv | 49 ++++
 rtl/xctcmsg_piton_noc_serializer.sv | 137 +++++++++++++
 tb/tb_xctcmsg_piton_noc_serializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/xctcmsg_piton_pkg.sv
// Shared types and helpers for the xctcmsg-to-OpenPiton NoC egress path.
// Header field widths follow the OpenPiton 64-bit header flit.
package xctcmsg_piton_pkg;

  localparam int unsigned NOC_HEADER_WIDTH         = 64;
  localparam int unsigned OPENPITON_FLIT_WIDTH     = 64;
  localparam int unsigned NOC_MSG_DST_CHIPID_WIDTH = 14;
  localparam int unsigned NOC_MSG_XY_WIDTH         = 8;
  localparam int unsigned NOC_MSG_FBITS_WIDTH      = 4;
  localparam int unsigned NOC_MSG_LENGTH_WIDTH     = 8;
  localparam int unsigned NOC_MSG_RSVD_WIDTH       = 22;
  localparam int unsigned NOC_MSG_PAYLOAD_LENGTH   = 2;
  localparam int unsigned OPENPITON_X_TILES        = 4;
  localparam int unsigned MESSAGE_ADDR_WIDTH       = 8;

  typedef logic [MESSAGE_ADDR_WIDTH-1:0]   message_addr_t;
  typedef logic [OPENPITON_FLIT_WIDTH-1:0] openpiton_flit_t;

  typedef struct packed {
    logic [NOC_MSG_DST_CHIPID_WIDTH-1:0] chipid;
    logic [NOC_MSG_XY_WIDTH-1:0]         x;
    logic [NOC_MSG_XY_WIDTH-1:0]         y;
    logic [NOC_MSG_FBITS_WIDTH-1:0]      fbits;
    logic [NOC_MSG_LENGTH_WIDTH-1:0]     len;
    logic [NOC_MSG_RSVD_WIDTH-1:0]       rsvd;
  } openpiton_noc_header_t;

  typedef enum logic [1:0] {
    StIdle,
    StHeader,
    StPayload
  } serializer_state_e;

  // Core ids are laid out row-major across the mesh.
  function automatic openpiton_noc_header_t build_noc_header(
    input logic [NOC_MSG_DST_CHIPID_WIDTH-1:0] chipid,
    input message_addr_t                       dst,
    input logic [NOC_MSG_LENGTH_WIDTH-1:0]     len,
    input int unsigned                         x_tiles,
    input logic [NOC_MSG_FBITS_WIDTH-1:0]      fbits
  );
    openpiton_noc_header_t h;
    h.chipid = chipid;
    h.x      = NOC_MSG_XY_WIDTH'(32'(dst) % x_tiles);
    h.y      = NOC_MSG_XY_WIDTH'(32'(dst) / x_tiles);
    h.fbits  = fbits;
    h.len    = len;
    h.rsvd   = '0;
    return h;
  endfunction

endpackage

// File: rtl/xctcmsg_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// moves the pointer past the grantee when the grant is consumed.
module xctcmsg_rr_arbiter #(
  parameter int unsigned NumChannels = 2,
  localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   advance_i,
  output logic [NumChannels-1:0] grant_o,
  output logic [IdxW-1:0]        grant_idx_o,
  output logic                   grant_valid_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] gidx;
  logic            found;
  int unsigned     idx;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      idx = (32'(ptr_q) + i) % NumChannels;
      if (!found && req_i[IdxW'(idx)]) begin
        found = 1'b1;
        gidx  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (found) grant_o[gidx] = 1'b1;
    grant_idx_o   = gidx;
    grant_valid_o = found;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && found) begin
      ptr_q <= (32'(gidx) == NumChannels - 1) ? '0 : gidx + IdxW'(1);
    end
  end

endmodule

// File: rtl/xctcmsg_piton_noc_serializer.sv
// Multi-channel xctcmsg egress serializer onto one OpenPiton NoC channel:
// round-robin pick, then one header flit followed by len payload flits.
module xctcmsg_piton_noc_serializer
  import xctcmsg_piton_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS      = 2,
  parameter int unsigned FLIT_WIDTH        = 64,
  parameter int unsigned MAX_PAYLOAD_FLITS = NOC_MSG_PAYLOAD_LENGTH,
  parameter int unsigned X_TILES           = OPENPITON_X_TILES,
  parameter logic [NOC_MSG_FBITS_WIDTH-1:0] DST_FBITS = 4'b0000
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NOC_MSG_DST_CHIPID_WIDTH-1:0]           chipid_i,
  input  logic [NUM_CHANNELS-1:0]                       req_valid_i,
  output logic [NUM_CHANNELS-1:0]                       req_ready_o,
  input  logic [NUM_CHANNELS*$bits(message_addr_t)-1:0] req_dst_i,
  input  logic [NUM_CHANNELS*NOC_MSG_LENGTH_WIDTH-1:0]  req_len_i,
  input  logic [NUM_CHANNELS*MAX_PAYLOAD_FLITS*FLIT_WIDTH-1:0] req_payload_i,
  output logic                                          noc_valid_o,
  output logic [FLIT_WIDTH-1:0]                         noc_data_o,
  input  logic                                          noc_ready_i,
  output logic                                          err_o,
  output logic                                          busy_o
);

  localparam int unsigned AddrW = $bits(message_addr_t);
  localparam int unsigned LenW  = NOC_MSG_LENGTH_WIDTH;
  localparam int unsigned MsgW  = MAX_PAYLOAD_FLITS * FLIT_WIDTH;
  localparam int unsigned IdxW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  if (FLIT_WIDTH != NOC_HEADER_WIDTH) begin : g_bad_flit_width
    $error("FLIT_WIDTH must equal NOC_HEADER_WIDTH");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16 ||
      MAX_PAYLOAD_FLITS < 1 || MAX_PAYLOAD_FLITS > 255) begin : g_bad_params
    $error("NUM_CHANNELS or MAX_PAYLOAD_FLITS out of range");
  end

  serializer_state_e state_q, state_d;

  logic [NUM_CHANNELS-1:0] grant;
  logic [IdxW-1:0]         gidx;
  logic                    arb_valid;
  logic                    accept;
  logic                    len_ok;
  logic [LenW-1:0]         sel_len;
  message_addr_t           sel_dst;
  logic [MsgW-1:0]         sel_payload;

  logic [FLIT_WIDTH-1:0]   hdr_q;
  logic [MsgW-1:0]         payload_q;
  logic [LenW-1:0]         len_q;
  logic [LenW-1:0]         cnt_q;
  logic                    err_q;
  logic                    last_flit;

  xctcmsg_rr_arbiter #(
    .NumChannels(NUM_CHANNELS)
  ) u_arb (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_valid_i),
    .advance_i    (accept),
    .grant_o      (grant),
    .grant_idx_o  (gidx),
    .grant_valid_o(arb_valid)
  );

  assign accept      = (state_q == StIdle) && arb_valid;
  assign sel_len     = req_len_i[gidx*LenW +: LenW];
  assign sel_dst     = req_dst_i[gidx*AddrW +: AddrW];
  assign sel_payload = req_payload_i[gidx*MsgW +: MsgW];
  assign len_ok      = (32'(sel_len) <= MAX_PAYLOAD_FLITS);
  assign last_flit   = (cnt_q == len_q - LenW'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept && len_ok) state_d = StHeader;
      StHeader:  if (noc_ready_i) state_d = (len_q == '0) ? StIdle : StPayload;
      StPayload: if (noc_ready_i && last_flit) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Oversized messages are still consumed; they only raise err_o next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hdr_q     <= '0;
      payload_q <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= accept && !len_ok;
      if (accept && len_ok) begin
        hdr_q     <= FLIT_WIDTH'(build_noc_header(chipid_i, sel_dst, sel_len, X_TILES, DST_FBITS));
        payload_q <= sel_payload;
        len_q     <= sel_len;
        cnt_q     <= '0;
      end else if (state_q == StHeader && noc_ready_i) begin
        cnt_q <= '0;
      end else if (state_q == StPayload && noc_ready_i && !last_flit) begin
        cnt_q <= cnt_q + LenW'(1);
      end
    end
  end

  always_comb begin
    req_ready_o = accept ? grant : '0;
    noc_valid_o = 1'b0;
    noc_data_o  = '0;
    case (state_q)
      StHeader: begin
        noc_valid_o = 1'b1;
        noc_data_o  = hdr_q;
      end
      StPayload: begin
        noc_valid_o = 1'b1;
        noc_data_o  = payload_q[cnt_q*FLIT_WIDTH +: FLIT_WIDTH];
      end
      default: ;
    endcase
    busy_o = (state_q != StIdle);
    err_o  = err_q;
  end

endmodule

// File: tb/tb_xctcmsg_piton_noc_serializer.sv
// Directed bench for the NoC serializer: header/payload sequencing, backpressure,
// round-robin alternation, zero-length and oversized messages, async reset.
module tb_xctcmsg_piton_noc_serializer;
  import xctcmsg_piton_pkg::*;

  logic         clk;
  logic         rst;
  logic [13:0]  chipid;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [15:0]  req_dst;
  logic [15:0]  req_len;
  logic [255:0] req_payload;
  logic         noc_valid;
  logic [63:0]  noc_data;
  logic         noc_ready;
  logic         err;
  logic         busy;

  int vectors;
  int miscompares;

  localparam logic [63:0] FA = 64'hA0A1_A2A3_A4A5_A6A7;
  localparam logic [63:0] FB = 64'hB0B1_B2B3_B4B5_B6B7;
  localparam logic [63:0] FC = 64'hC0C1_C2C3_C4C5_C6C7;
  localparam logic [63:0] FD = 64'hD0D1_D2D3_D4D5_D6D7;
  localparam logic [63:0] FE = 64'hE0E1_E2E3_E4E5_E6E7;
  localparam logic [63:0] FF = 64'hF0F1_F2F3_F4F5_F6F7;

  xctcmsg_piton_noc_serializer #(
    .NUM_CHANNELS     (2),
    .FLIT_WIDTH       (64),
    .MAX_PAYLOAD_FLITS(2),
    .X_TILES          (4),
    .DST_FBITS        (4'b0000)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .chipid_i     (chipid),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_dst_i    (req_dst),
    .req_len_i    (req_len),
    .req_payload_i(req_payload),
    .noc_valid_o  (noc_valid),
    .noc_data_o   (noc_data),
    .noc_ready_i  (noc_ready),
    .err_o        (err),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input logic [13:0] c, input logic [7:0] x,
                                      input logic [7:0] y, input logic [7:0] len);
    return {c, x, y, 4'b0000, len, 22'd0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] dst, input logic [7:0] len,
                        input logic [63:0] f0, input logic [63:0] f1);
    req_dst[c*8 +: 8]           = dst;
    req_len[c*8 +: 8]           = len;
    req_payload[c*128 +: 64]    = f0;
    req_payload[c*128+64 +: 64] = f1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    chipid = 14'h0123;
    req_valid = '0;
    req_dst = '0;
    req_len = '0;
    req_payload = '0;
    noc_ready = 1'b0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(noc_valid), 64'd0);
    chk("rst_data", noc_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;

    // Basic len=2 message on ch0, dst 5 -> x=1, y=1
    set_ch(0, 8'd5, 8'd2, FA, FB);
    noc_ready = 1'b1;
    req_valid = 2'b01;
    #1;
    chk("t1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("t1_hdr_valid", 64'(noc_valid), 64'd1);
    chk("t1_hdr", noc_data, hdr(14'h0123, 8'd1, 8'd1, 8'd2));
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_ready_busy", 64'(req_ready), 64'd0);
    tick();
    chk("t1_flitA", noc_data, FA);
    tick();
    chk("t1_flitB", noc_data, FB);
    chk("t1_flitB_valid", 64'(noc_valid), 64'd1);
    tick();
    chk("t1_idle_valid", 64'(noc_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Backpressure for 3 cycles during flit A
    req_valid = 2'b01;
    #1;
    chk("t2_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("t2_hdr", noc_data, hdr(14'h0123, 8'd1, 8'd1, 8'd2));
    tick();
    chk("t2_flitA0", noc_data, FA);
    noc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_valid", 64'(noc_valid), 64'd1);
      chk("t2_hold_data", noc_data, FA);
    end
    noc_ready = 1'b1;
    tick();
    chk("t2_flitB", noc_data, FB);
    tick();
    chk("t2_idle", 64'(noc_valid), 64'd0);

    // Pointer is now 1: zero-length message on ch1, dst 6 -> x=2, y=1
    set_ch(1, 8'd6, 8'd0, FC, FD);
    req_valid = 2'b10;
    #1;
    chk("t4_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = 2'b00;
    chk("t4_hdr_valid", 64'(noc_valid), 64'd1);
    chk("t4_hdr", noc_data, hdr(14'h0123, 8'd2, 8'd1, 8'd0));
    tick();
    chk("t4_idle_valid", 64'(noc_valid), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("t4_no_payload", 64'(noc_valid), 64'd0);

    // Both channels valid, len=1: accepts alternate 0,1,0 every 3 cycles
    set_ch(0, 8'd1, 8'd1, FC, FF);
    set_ch(1, 8'd2, 8'd1, FD, FF);
    req_valid = 2'b11;
    #1;
    chk("t3_ready0", 64'(req_ready), 64'd1);
    tick();
    chk("t3_hdr0", noc_data, hdr(14'h0123, 8'd1, 8'd0, 8'd1));
    chk("t3_wait0", 64'(req_ready), 64'd0);
    tick();
    chk("t3_pay0", noc_data, FC);
    tick();
    chk("t3_ready1", 64'(req_ready), 64'd2);
    tick();
    chk("t3_hdr1", noc_data, hdr(14'h0123, 8'd2, 8'd0, 8'd1));
    tick();
    chk("t3_pay1", noc_data, FD);
    tick();
    chk("t3_ready0b", 64'(req_ready), 64'd1);
    req_valid = 2'b00;
    #1;
    chk("t3_drop", 64'(req_ready), 64'd0);

    // Oversized message: consumed, err pulse, no flits, pointer advances
    tick();
    set_ch(0, 8'd3, 8'd3, FA, FB);
    req_valid = 2'b01;
    #1;
    chk("t5_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_valid", 64'(noc_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    tick();
    chk("t5_err_pulse", 64'(err), 64'd0);
    chk("t5_valid2", 64'(noc_valid), 64'd0);
    req_valid = 2'b11;
    set_ch(1, 8'd2, 8'd1, FD, FF);
    #1;
    chk("t5_ptr", 64'(req_ready), 64'd2);
    req_valid = 2'b00;

    // Reset in the middle of the payload, then a fresh message
    tick();
    set_ch(0, 8'd5, 8'd2, FA, FB);
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    chk("t6_hdr", noc_data, hdr(14'h0123, 8'd1, 8'd1, 8'd2));
    tick();
    chk("t6_flitA", noc_data, FA);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(noc_valid), 64'd0);
    chk("t6_rst_data", noc_data, 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b0;
    set_ch(0, 8'd5, 8'd2, FE, FF);
    chipid = 14'h02AB;
    req_valid = 2'b01;
    #1;
    chk("t6_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 2'b00;
    chipid = 14'h3FFF;
    chk("t6_new_hdr", noc_data, hdr(14'h02AB, 8'd1, 8'd1, 8'd2));
    tick();
    chk("t6_new_flit0", noc_data, FE);
    tick();
    chk("t6_new_flit1", noc_data, FF);
    tick();
    chk("t6_new_idle", 64'(noc_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
